// File: rtl/wb_commit.sv
// Writeback/commit: registers both lane bundles, orders them by tag, drops older write on same-rd collision.
// Latency: 1 cycle capture -> write ports/forwarding valid next cycle. Optional WB_INSTRET_EN adds instret.
// Backpressure: stop/flush capture a bubble; upstream holds its outputs, so each instruction commits once.
module wb_commit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RFW_W  = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop,
    input  logic              flush,
    input  logic              l0_v,
    input  logic              l0_num,
    input  logic [RFW_W-1:0]  l0_rfw,
    input  logic              l1_v,
    input  logic              l1_num,
    input  logic [RFW_W-1:0]  l1_rfw,
    output logic              wp0_we,
    output logic [ADDR_W-1:0] wp0_addr,
    output logic [DATA_W-1:0] wp0_data,
    output logic              wp1_we,
    output logic [ADDR_W-1:0] wp1_addr,
    output logic [DATA_W-1:0] wp1_data,
    output logic [RFW_W-1:0]  fwd0,
    output logic [RFW_W-1:0]  fwd1,
    output logic [1:0]        retire_cnt,
    output logic              num_err
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       instret
`endif
);

    typedef struct packed {
        logic              we;
        logic              c;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rfw_t;

    logic cap_v0, cap_v1, cap_n0, cap_n1;
    rfw_t cap_b0, cap_b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v0 <= 1'b0;
            cap_v1 <= 1'b0;
            cap_n0 <= 1'b0;
            cap_n1 <= 1'b0;
            cap_b0 <= '0;
            cap_b1 <= '0;
        end else if (flush || stop) begin
            cap_v0 <= 1'b0;
            cap_v1 <= 1'b0;
            cap_n0 <= 1'b0;
            cap_n1 <= 1'b0;
            cap_b0 <= '0;
            cap_b1 <= '0;
        end else begin
            cap_v0 <= l0_v;
            cap_v1 <= l1_v;
            cap_n0 <= l0_num;
            cap_n1 <= l1_num;
            cap_b0 <= rfw_t'(l0_rfw);
            cap_b1 <= rfw_t'(l1_rfw);
        end
    end

    // Tag mismatch detection is gated by stop so a held pair is judged only once it is really captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_err <= 1'b0;
        end else if (!stop && l0_v && l1_v && (l0_num == l1_num)) begin
            num_err <= 1'b1;
        end
    end

    logic old_is_l1;
    logic old_v, young_v;
    rfw_t old_b, young_b;
    logic old_en, young_en, collide;
    rfw_t fwd0_b, fwd1_b;

    // A lone valid lane always lands on port 0; equal tags fall back to lane 0 as older.
    assign old_is_l1 = cap_v1 & (~cap_v0 | (cap_n0 & ~cap_n1));

    always_comb begin
        old_v   = cap_v0;
        young_v = cap_v1;
        old_b   = cap_b0;
        young_b = cap_b1;
        if (old_is_l1) begin
            old_v   = cap_v1;
            young_v = cap_v0;
            old_b   = cap_b1;
            young_b = cap_b0;
        end
    end

    assign old_en   = old_v & old_b.we & old_b.c & (|old_b.addr);
    assign young_en = young_v & young_b.we & young_b.c & (|young_b.addr);
    assign collide  = old_en & young_en & (old_b.addr == young_b.addr);

    assign wp0_we   = old_en & ~collide;
    assign wp0_addr = old_b.addr;
    assign wp0_data = old_b.data;
    assign wp1_we   = young_en;
    assign wp1_addr = young_b.addr;
    assign wp1_data = young_b.data;

    always_comb begin
        fwd0_b    = old_b;
        fwd1_b    = young_b;
        fwd0_b.we = old_b.we & old_v & ~collide;
        fwd1_b.we = young_b.we & young_v;
    end

    assign fwd0       = fwd0_b;
    assign fwd1       = fwd1_b;
    assign retire_cnt = {1'b0, cap_v0} + {1'b0, cap_v1};

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 64'd0;
        end else begin
            instret <= instret + 64'(retire_cnt);
        end
    end
`endif

endmodule
